// File: rtl/vga_pll_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : vga_pll_seq_pkg                                                |
// | Shared types and constants for the VGA pixel-PLL bring-up sequencer:     |
// | debug-visible state encoding, default timing constants (27 MHz refclk),  |
// | retry counter width and a small helper for sizing the cycle counter.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vga_pll_seq_pkg;

  // The encoding is exported on state_dbg, so values are pinned explicitly.
  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  localparam int C_DEF_RST_CYCLES   = 270;    // 10 us at 27 MHz
  localparam int C_DEF_LOCK_TIMEOUT = 27000;  // 1 ms at 27 MHz
  localparam int C_DEF_LOCK_STABLE  = 2700;   // 100 us at 27 MHz
  localparam int C_DEF_MAX_RETRIES  = 3;

  localparam int C_RETRY_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sync_2ff                                                       |
// | Two-flop synchronizer for quasi-static bits crossing into i_clk.         |
// | Ports   : i_clk   - destination clock                                    |
// |           i_rst_n - asynchronous active-low clear of both stages         |
// |           i_d     - asynchronous input bits [WIDTH-1:0]                  |
// |           o_q     - synchronized bits, two i_clk cycles behind i_d       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_pll_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : vga_pll_sequencer                                              |
// | Brings up the VGA pixel PLL: pulses its reset, waits for lock with a     |
// | timeout and bounded retries, qualifies lock for a stable interval, then  |
// | signals ready. Loss of lock in RUN restarts the sequence.                |
// | Ports   : i_refclk     - 27 MHz reference, sole clock                    |
// |           i_rst_n      - asynchronous active-low reset                   |
// |           i_pll_locked - PLL lock flag (asynchronous)                    |
// |           i_restart    - one-cycle request to re-run the sequence        |
// |           o_pll_rst    - active-high reset to the PLL                    |
// |           o_ready      - lock qualified, pixel logic may start           |
// |           o_fault      - retries exhausted, sequence halted              |
// |           o_lock_lost  - one-cycle pulse on lock loss while ready        |
// |           o_retry_cnt  - failed attempts in current sequence             |
// |           o_state_dbg  - current state encoding                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_pll_sequencer
  import vga_pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = C_DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = C_DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = C_DEF_LOCK_STABLE,
  parameter int MAX_RETRIES  = C_DEF_MAX_RETRIES
) (
  input  logic                 i_refclk,
  input  logic                 i_rst_n,
  input  logic                 i_pll_locked,
  input  logic                 i_restart,
  output logic                 o_pll_rst,
  output logic                 o_ready,
  output logic                 o_fault,
  output logic                 o_lock_lost,
  output logic [C_RETRY_W-1:0] o_retry_cnt,
  output logic [2:0]           o_state_dbg
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE) + 1);

  localparam logic [CNT_W-1:0]     C_RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]     C_TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     C_STB_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [C_RETRY_W-1:0] C_MAX_RETRY = C_RETRY_W'(MAX_RETRIES);

  generate
    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE < 1 || MAX_RETRIES < 1) begin : g_bad_zero_param
      $error("vga_pll_sequencer: RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE and MAX_RETRIES must be non-zero");
    end
    if (MAX_RETRIES >= (2 ** C_RETRY_W)) begin : g_bad_retry_param
      $error("vga_pll_sequencer: MAX_RETRIES does not fit the retry counter");
    end
  endgenerate

  logic                 w_locked_s;
  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [C_RETRY_W-1:0] r_retry;
  logic [C_RETRY_W-1:0] w_retry_nxt;
  logic [C_RETRY_W-1:0] w_retry_inc;
  logic                 w_lock_lost_nxt;
  logic                 r_pll_rst;
  logic                 r_ready;
  logic                 r_fault;
  logic                 r_lock_lost;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .i_clk   (i_refclk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_locked),
    .o_q     (w_locked_s)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_retry_nxt     = r_retry;
    w_lock_lost_nxt = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_retry_inc     = (r_retry >= C_MAX_RETRY) ? r_retry : r_retry + C_RETRY_W'(1);

    if (i_restart) begin
      w_state_nxt = S_RESET_PLL;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == C_RST_LAST) w_state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          // Lock is tested first so a lock arriving on the timeout cycle wins.
          if (w_locked_s) begin
            w_state_nxt = S_STABLE;
          end else if (r_cnt == C_TMO_LAST) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == C_MAX_RETRY) ? S_FAULT : S_RESET_PLL;
          end
        end
        S_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = S_WAIT_LOCK;
          end else if (r_cnt == C_STB_LAST) begin
            w_state_nxt = S_RUN;
            w_retry_nxt = '0;
          end
        end
        S_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt     = S_RESET_PLL;
            w_lock_lost_nxt = 1'b1;
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
        end
      endcase
    end

    // Counter restarts on every state change (and on restart, which may
    // re-enter RESET_PLL from itself); it only advances in timed states,
    // all of which exit before reaching their limit, so it never wraps.
    if (i_restart || (w_state_nxt != r_state)) begin
      w_cnt_nxt = '0;
    end else if (r_state inside {S_RESET_PLL, S_WAIT_LOCK, S_STABLE}) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
      r_ready     <= (w_state_nxt == S_RUN);
      r_fault     <= (w_state_nxt == S_FAULT);
      r_lock_lost <= w_lock_lost_nxt;
    end
  end

  assign o_pll_rst   = r_pll_rst;
  assign o_ready     = r_ready;
  assign o_fault     = r_fault;
  assign o_lock_lost = r_lock_lost;
  assign o_retry_cnt = r_retry;
  assign o_state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vga_pll_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_vga_pll_sequencer                                           |
// | Self-checking bench for vga_pll_sequencer with short timing parameters.  |
// | A behavioural model predicts every cycle's outputs into a queue; a       |
// | monitor pops and compares against the DUT.                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vga_pll_sequencer;
  import vga_pll_seq_pkg::*;

  localparam int RST_C = 4;
  localparam int TMO_C = 16;
  localparam int STB_C = 8;
  localparam int MAXR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, ready, fault, lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  vga_pll_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TMO_C),
    .LOCK_STABLE  (STB_C),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .i_refclk     (clk),
    .i_rst_n      (rst_n),
    .i_pll_locked (pll_locked),
    .i_restart    (restart),
    .o_pll_rst    (pll_rst),
    .o_ready      (ready),
    .o_fault      (fault),
    .o_lock_lost  (lock_lost),
    .o_retry_cnt  (retry_cnt),
    .o_state_dbg  (state_dbg)
  );

  typedef struct packed {
    logic       pll_rst;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [3:0] retry;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // ---------------- reference model ----------------
  typedef enum int {PH_RST, PH_WAIT, PH_STB, PH_RUN, PH_FLT} ph_e;

  ph_e ph;
  int  cyc = 0;
  int  t_enter = 0;
  int  retries = 0;
  bit  lk1 = 0, lk2 = 0;

  function automatic logic [2:0] dbg_of(input ph_e p);
    case (p)
      PH_RST:  return S_RESET_PLL;
      PH_WAIT: return S_WAIT_LOCK;
      PH_STB:  return S_STABLE;
      PH_RUN:  return S_RUN;
      default: return S_FAULT;
    endcase
  endfunction

  function automatic exp_t mk_exp(input ph_e p, input int r, input bit ll);
    exp_t e;
    e.pll_rst   = (p == PH_RST) || (p == PH_FLT);
    e.ready     = (p == PH_RUN);
    e.fault     = (p == PH_FLT);
    e.lock_lost = ll;
    e.retry     = 4'(r);
    e.st        = dbg_of(p);
    return e;
  endfunction

  initial begin
    bit  ls, ll;
    ph_e np;
    forever begin
      @(posedge clk or negedge rst_n);
      cyc++;
      if (!rst_n) begin
        ph = PH_RST; retries = 0; lk1 = 0; lk2 = 0; t_enter = cyc;
        exp_q.delete();
        exp_q.push_back(mk_exp(PH_RST, 0, 1'b0));
      end else begin
        ls = lk2; lk2 = lk1; lk1 = pll_locked;  // two-cycle lag on lock
        ll = 1'b0;
        np = ph;
        if (restart) begin
          np = PH_RST; retries = 0; t_enter = cyc;
        end else begin
          case (ph)
            PH_RST:  if (cyc - t_enter == RST_C) np = PH_WAIT;
            PH_WAIT: begin
              if (ls) np = PH_STB;
              else if (cyc - t_enter == TMO_C) begin
                retries = (retries + 1 > MAXR) ? MAXR : retries + 1;
                np = (retries == MAXR) ? PH_FLT : PH_RST;
              end
            end
            PH_STB: begin
              if (!ls) np = PH_WAIT;
              else if (cyc - t_enter == STB_C) begin np = PH_RUN; retries = 0; end
            end
            PH_RUN:  if (!ls) begin np = PH_RST; ll = 1'b1; end
            default: np = PH_FLT;
          endcase
        end
        if (np != ph) t_enter = cyc;
        ph = np;
        exp_q.push_back(mk_exp(ph, retries, ll));
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pll_rst",   8'(pll_rst),   8'(e.pll_rst));
        chk("ready",     8'(ready),     8'(e.ready));
        chk("fault",     8'(fault),     8'(e.fault));
        chk("lock_lost", 8'(lock_lost), 8'(e.lock_lost));
        chk("retry_cnt", 8'(retry_cnt), 8'(e.retry));
        chk("state_dbg", 8'(state_dbg), 8'(e.st));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic async_reset(input int n);
    #2 rst_n = 1'b0;
    wait_cyc(n);
    rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;

    // Normal bring-up: lock 3 cycles after pll_rst falls, then held.
    wait_cyc(RST_C + 3);
    pll_locked = 1'b1;
    wait_cyc(30);

    // Lock lost in RUN, then never returns -> retries exhaust into FAULT.
    pll_locked = 1'b0;
    wait_cyc(70);

    // Restart out of FAULT, then lock normally.
    pulse_restart();
    wait_cyc(6);
    pll_locked = 1'b1;
    wait_cyc(30);

    // One-cycle lock glitch while qualifying lock.
    pulse_restart();
    wait_cyc(7);
    pll_locked = 1'b0;
    wait_cyc(1);
    pll_locked = 1'b1;
    wait_cyc(30);

    // Asynchronous reset while waiting for lock.
    pll_locked = 1'b0;
    pulse_restart();
    wait_cyc(10);
    async_reset(3);
    wait_cyc(10);

    // Randomized lock behaviour with occasional restart and reset.
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      pll_locked = ($urandom_range(0, 2) != 0);
      len = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 60);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        restart = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 399) == 0) begin
          restart = 1'b0;
          async_reset($urandom_range(1, 3));
        end
      end
    end
    restart = 1'b0;
    wait_cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
